// File: rtl/riscv32_mem_pkg.sv
// Shared memory-subsystem definitions: arbiter state encoding, master IDs and
// the default RAM address/data widths.
package riscv32_mem_pkg;

  localparam int unsigned DEF_AW  = 8;
  localparam int unsigned DEF_DW  = 32;
  // Burst counter width; holds MAX_BURST values up to 15.
  localparam int unsigned BURST_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arbStateT;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } masterT;

  // The master that is not m.
  function automatic masterT otherMaster(input masterT m);
    return (m == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection for memory_ram_arbiter.
// A locked re-grant to the current holder takes precedence while its burst
// budget lasts; otherwise a lone requester wins and ties are broken by
// fixed priority (M0) or, with RAM_ARB_RR_EN defined, round-robin against
// lastGrant.
// Ports:
//   ackPhase      - arbiter is in its ACK state (lock is only honoured there)
//   req, lock     - {M1, M0} request and lock bits
//   grant         - master of the transaction now completing
//   lastGrant     - most recent winner (RAM_ARB_RR_EN builds only)
//   burstCnt      - locked re-grants issued to the holder so far
//   winner_c      - selected master
//   anyReq_c      - at least one request pending
//   lockRegrant_c - the selection is a locked re-grant to the holder
module ram_arb_pick
  import riscv32_mem_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               ackPhase,
  input  logic [1:0]         req,
  input  logic [1:0]         lock,
  input  masterT             grant,
`ifdef RAM_ARB_RR_EN
  input  masterT             lastGrant,
`endif
  input  logic [BURST_W-1:0] burstCnt,
  output masterT             winner_c,
  output logic               anyReq_c,
  output logic               lockRegrant_c
);

  logic holdReq;
  logic holdLock;
  logic lockHold;

  always_comb begin
    holdReq       = (grant == M1) ? req[1]  : req[0];
    holdLock      = (grant == M1) ? lock[1] : lock[0];
    lockHold      = ackPhase && holdReq && holdLock &&
                    (burstCnt < BURST_W'(MAX_BURST));
    anyReq_c      = |req;
    winner_c      = M0;
    lockRegrant_c = 1'b0;

    if (lockHold) begin
      winner_c = grant;
    end else if (req[0] && req[1]) begin
`ifdef RAM_ARB_RR_EN
      winner_c = otherMaster(lastGrant);
`else
      winner_c = M0;
`endif
    end else if (req[1]) begin
      winner_c = M1;
    end else begin
      winner_c = M0;
    end

    // Holder re-granted with lock up, including the uncontested case past
    // the budget; the counter saturates in that case.
    lockRegrant_c = ackPhase && holdReq && holdLock && (winner_c == grant);
  end

endmodule

// File: rtl/memory_ram_arbiter.sv
// Two-master arbiter in front of the data RAM. M0 is the CPU data port, M1 a
// secondary master (loader, debug/DMA). Single-word transactions run
// IDLE -> ACCESS (one-cycle RAM strobe) -> ACK (one-cycle ACK pulse with read
// data); back-to-back requests go straight from ACK to ACCESS.
// Optional macro RAM_ARB_RR_EN: round-robin tie break (default: M0 priority).
// Ports:
//   iCLK, iRST                - clock, async active-low reset
//   iMx_REQ/WR/LOCK/ADDR/WDATA - master request bus, x = 0/1
//   oMx_ACK, oMx_RDATA        - completion pulse and held read data
//   oRAM_CE/RD/WR/ADDR/DATA   - registered RAM strobes, address, write data
//   iRAM_DATA                 - RAM read data, valid while CE and RD are high
module memory_ram_arbiter
  import riscv32_mem_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iM0_REQ,
  input  logic          iM0_WR,
  input  logic          iM0_LOCK,
  input  logic [AW-1:0] iM0_ADDR,
  input  logic [DW-1:0] iM0_WDATA,
  input  logic          iM1_REQ,
  input  logic          iM1_WR,
  input  logic          iM1_LOCK,
  input  logic [AW-1:0] iM1_ADDR,
  input  logic [DW-1:0] iM1_WDATA,
  output logic          oM0_ACK,
  output logic [DW-1:0] oM0_RDATA,
  output logic          oM1_ACK,
  output logic [DW-1:0] oM1_RDATA,
  output logic          oRAM_CE,
  output logic          oRAM_RD,
  output logic          oRAM_WR,
  output logic [AW-1:0] oRAM_ADDR,
  output logic [DW-1:0] oRAM_DATA,
  input  logic [DW-1:0] iRAM_DATA
);

  arbStateT           state;
  masterT             grant;
  logic [BURST_W-1:0] burstCnt;
`ifdef RAM_ARB_RR_EN
  masterT             lastGrant;
`endif

  masterT        winner;
  logic          anyReq;
  logic          lockRegrant;
  logic          grantNow;
  logic          selWr;
  logic [AW-1:0] selAddr;
  logic [DW-1:0] selWdata;

  ram_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) uPick (
    .ackPhase      (state == ACK),
    .req           ({iM1_REQ, iM0_REQ}),
    .lock          ({iM1_LOCK, iM0_LOCK}),
    .grant         (grant),
`ifdef RAM_ARB_RR_EN
    .lastGrant     (lastGrant),
`endif
    .burstCnt      (burstCnt),
    .winner_c      (winner),
    .anyReq_c      (anyReq),
    .lockRegrant_c (lockRegrant)
  );

  // Request bus of the arbitration winner.
  assign selWr    = (winner == M1) ? iM1_WR    : iM0_WR;
  assign selAddr  = (winner == M1) ? iM1_ADDR  : iM0_ADDR;
  assign selWdata = (winner == M1) ? iM1_WDATA : iM0_WDATA;

  // A new grant is issued from IDLE or ACK whenever anyone is requesting.
  assign grantNow = anyReq && ((state == IDLE) || (state == ACK));

  // Arbiter FSM, burst counter and registered RAM/master outputs.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state     <= IDLE;
      grant     <= M0;
      burstCnt  <= '0;
`ifdef RAM_ARB_RR_EN
      lastGrant <= M1;
`endif
      oM0_ACK   <= 1'b0;
      oM1_ACK   <= 1'b0;
      oM0_RDATA <= '0;
      oM1_RDATA <= '0;
      oRAM_CE   <= 1'b0;
      oRAM_RD   <= 1'b0;
      oRAM_WR   <= 1'b0;
      oRAM_ADDR <= '0;
      oRAM_DATA <= '0;
    end else begin
      // Strobes and ACKs are single-cycle pulses.
      oRAM_CE <= 1'b0;
      oRAM_RD <= 1'b0;
      oRAM_WR <= 1'b0;
      oM0_ACK <= 1'b0;
      oM1_ACK <= 1'b0;

      if (grantNow) begin
        grant     <= winner;
`ifdef RAM_ARB_RR_EN
        lastGrant <= winner;
`endif
        oRAM_CE   <= 1'b1;
        oRAM_RD   <= ~selWr;
        oRAM_WR   <= selWr;
        oRAM_ADDR <= selAddr;
        oRAM_DATA <= selWdata;
      end

      case (state)
        IDLE: begin
          burstCnt <= '0;
          if (anyReq) begin
            state <= ACCESS;
          end
        end

        ACCESS: begin
          // Completes even if the master dropped REQ during the access.
          state <= ACK;
          if (grant == M1) begin
            oM1_ACK <= 1'b1;
            if (oRAM_RD) begin
              oM1_RDATA <= iRAM_DATA;
            end
          end else begin
            oM0_ACK <= 1'b1;
            if (oRAM_RD) begin
              oM0_RDATA <= iRAM_DATA;
            end
          end
        end

        ACK: begin
          if (anyReq) begin
            state <= ACCESS;
            if (winner != grant) begin
              burstCnt <= '0;
            end else if (lockRegrant && (burstCnt < BURST_W'(MAX_BURST))) begin
              burstCnt <= burstCnt + BURST_W'(1);
            end
          end else begin
            state    <= IDLE;
            burstCnt <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_ram_arbiter.sv
// Directed bench for memory_ram_arbiter: a vector table for single
// transactions and ties, plus hand sequences for alternation, locked bursts,
// REQ dropped in ACCESS and reset in ACCESS. A small RAM model sits on the
// RAM port.
module tb_memory_ram_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          iCLK;
  logic          rstN;
  logic          m0Req, m0Wr, m0Lock, m1Req, m1Wr, m1Lock;
  logic [AW-1:0] m0Addr, m1Addr;
  logic [DW-1:0] m0Wdata, m1Wdata;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ramCe, ramRd, ramWr;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramWdata, ramRdata;

  memory_ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .iCLK      (iCLK),
    .iRST      (rstN),
    .iM0_REQ   (m0Req),
    .iM0_WR    (m0Wr),
    .iM0_LOCK  (m0Lock),
    .iM0_ADDR  (m0Addr),
    .iM0_WDATA (m0Wdata),
    .iM1_REQ   (m1Req),
    .iM1_WR    (m1Wr),
    .iM1_LOCK  (m1Lock),
    .iM1_ADDR  (m1Addr),
    .iM1_WDATA (m1Wdata),
    .oM0_ACK   (ack0),
    .oM0_RDATA (rdata0),
    .oM1_ACK   (ack1),
    .oM1_RDATA (rdata1),
    .oRAM_CE   (ramCe),
    .oRAM_RD   (ramRd),
    .oRAM_WR   (ramWr),
    .oRAM_ADDR (ramAddr),
    .oRAM_DATA (ramWdata),
    .iRAM_DATA (ramRdata)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // RAM model: synchronous write, combinational read.
  logic [DW-1:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge iCLK) if (ramCe && ramWr) mem[ramAddr] <= ramWdata;
  assign ramRdata = (ramCe && ramRd) ? mem[ramAddr] : '0;

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          eCe, eRd, eWr;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eData;
    logic          eAck0, eAck1;
    logic [DW-1:0] eRd0, eRd1;
  } vecT;

  vecT vecs [14];
  vecT v;
  int  nVec, nMis;
  int  who, cyc, m1Count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Advance until an ACK is seen; who = 0/1, or -1 on timeout.
  task automatic waitAck(input int limit, output int whoOut, output int cycOut);
    whoOut = -1;
    cycOut = 0;
    while (cycOut < limit) begin
      tick();
      cycOut++;
      if (ack0 || ack1) begin
        whoOut = ack1 ? 1 : 0;
        check("ackExclusive", 32'(ack0 & ack1), 32'd0);
        break;
      end
    end
    nVec++;
    if (whoOut < 0) begin
      nMis++;
      $display("FAIL ackWait: no ACK within %0d cycles", limit);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".ce"},    32'(ramCe),  32'd0);
    check({tag, ".rd"},    32'(ramRd),  32'd0);
    check({tag, ".wr"},    32'(ramWr),  32'd0);
    check({tag, ".addr"},  32'(ramAddr), 32'd0);
    check({tag, ".data"},  ramWdata,    32'd0);
    check({tag, ".ack0"},  32'(ack0),   32'd0);
    check({tag, ".ack1"},  32'(ack1),   32'd0);
    check({tag, ".rdat0"}, rdata0,      32'd0);
    check({tag, ".rdat1"}, rdata1,      32'd0);
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    rstN = 1'b0;
    {m0Req, m0Wr, m0Lock, m1Req, m1Wr, m1Lock} = '0;
    m0Addr = '0; m1Addr = '0; m0Wdata = '0; m1Wdata = '0;

    //          r0 w0 a0     d0            r1 w1 a1     d1            ce rd wr addr  data          k0 k1 rdata0        rdata1
    vecs[0]  = '{1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0,       1, 0, 1, 8'h10, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0};
    vecs[1]  = '{1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0,       0, 0, 0, 8'h00, 32'h0,        1, 0, 32'h0,        32'h0};
    vecs[2]  = '{0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,       0, 0, 0, 8'h00, 32'h0,        0, 0, 32'h0,        32'h0};
    vecs[3]  = '{1, 0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h0,       1, 1, 0, 8'h10, 32'h0,        0, 0, 32'h0,        32'h0};
    vecs[4]  = '{1, 0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h0,       0, 0, 0, 8'h00, 32'h0,        1, 0, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,       0, 0, 0, 8'h00, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0};
    vecs[6]  = '{0, 0, 8'h00, 32'h0,        1, 1, 8'h20, 32'hCAFEF00D, 1, 0, 1, 8'h20, 32'hCAFEF00D, 0, 0, 32'hDEADBEEF, 32'h0};
    vecs[7]  = '{0, 0, 8'h00, 32'h0,        1, 1, 8'h20, 32'hCAFEF00D, 0, 0, 0, 8'h00, 32'h0,        0, 1, 32'hDEADBEEF, 32'h0};
    vecs[8]  = '{0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,       0, 0, 0, 8'h00, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0};
    vecs[9]  = '{1, 0, 8'h20, 32'h0,        1, 0, 8'h10, 32'h0,       1, 1, 0, 8'h20, 32'h0,        0, 0, 32'hDEADBEEF, 32'h0};
    vecs[10] = '{1, 0, 8'h20, 32'h0,        1, 0, 8'h10, 32'h0,       0, 0, 0, 8'h00, 32'h0,        1, 0, 32'hCAFEF00D, 32'h0};
    vecs[11] = '{0, 0, 8'h00, 32'h0,        1, 0, 8'h10, 32'h0,       1, 1, 0, 8'h10, 32'h0,        0, 0, 32'hCAFEF00D, 32'h0};
    vecs[12] = '{0, 0, 8'h00, 32'h0,        1, 0, 8'h10, 32'h0,       0, 0, 0, 8'h00, 32'h0,        0, 1, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[13] = '{0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,       0, 0, 0, 8'h00, 32'h0,        0, 0, 32'hCAFEF00D, 32'hDEADBEEF};

    // Reset state.
    #12;
    checkAllZero("reset");
    #10 rstN = 1'b1;
    tick();
    checkAllZero("postReset");

    // Single transactions and a tie, one edge per vector.
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      m0Req = v.r0; m0Wr = v.w0; m0Addr = v.a0; m0Wdata = v.d0;
      m1Req = v.r1; m1Wr = v.w1; m1Addr = v.a1; m1Wdata = v.d1;
      tick();
      check($sformatf("v%0d.ce", i),    32'(ramCe), 32'(v.eCe));
      check($sformatf("v%0d.rd", i),    32'(ramRd), 32'(v.eRd));
      check($sformatf("v%0d.wr", i),    32'(ramWr), 32'(v.eWr));
      check($sformatf("v%0d.ack0", i),  32'(ack0),  32'(v.eAck0));
      check($sformatf("v%0d.ack1", i),  32'(ack1),  32'(v.eAck1));
      check($sformatf("v%0d.rdat0", i), rdata0,     v.eRd0);
      check($sformatf("v%0d.rdat1", i), rdata1,     v.eRd1);
      if (v.eCe) check($sformatf("v%0d.addr", i), 32'(ramAddr), 32'(v.eAddr));
      if (v.eCe && v.eWr) check($sformatf("v%0d.wdata", i), ramWdata, v.eData);
    end

    // Continuous tie: M0 always (fixed) or alternating from M0 (round-robin).
    m0Req = 1; m0Wr = 0; m0Addr = 8'h10;
    m1Req = 1; m1Wr = 0; m1Addr = 8'h20;
    for (int k = 0; k < 6; k++) begin
      waitAck(4, who, cyc);
      check($sformatf("tie%0d.who", k), 32'(who), (RR && (k % 2 == 1)) ? 32'd1 : 32'd0);
      check($sformatf("tie%0d.gap", k), 32'(cyc), 32'd2);
      if (who == 1) check($sformatf("tie%0d.rdat1", k), rdata1, 32'hCAFEF00D);
      else          check($sformatf("tie%0d.rdat0", k), rdata0, 32'hDEADBEEF);
    end
    m0Req = 0; m1Req = 0;
    tick();
    check("tieIdle.ce", 32'(ramCe), 32'd0);
    tick();
    check("tieIdle.ack", 32'({ack0, ack1}), 32'd0);

    // M1 locked burst; M0 starts requesting in M1's first ACK cycle.
    m1Req = 1; m1Wr = 0; m1Addr = 8'h20; m1Lock = 1;
    waitAck(4, who, cyc);
    check("lock.first", 32'(who), 32'd1);
    check("lock.latency", 32'(cyc), 32'd2);
    m0Req = 1; m0Wr = 0; m0Addr = 8'h10;
    m1Count = 0;
    for (int k = 0; k < 8; k++) begin
      waitAck(4, who, cyc);
      check($sformatf("lock%0d.gap", k), 32'(cyc), 32'd2);
      if (who != 1) break;
      m1Count++;
    end
    check("lock.m1Count", 32'(m1Count), 32'd4);
    check("lock.m0Wins", 32'(who), 32'd0);
    m0Req = 0;
    waitAck(4, who, cyc);
    check("lock.m1Resumes", 32'(who), 32'd1);
    check("lock.resumeGap", 32'(cyc), 32'd2);

    // Uncontested locked burst runs on; the counter must not wrap.
    for (int k = 0; k < 20; k++) begin
      waitAck(4, who, cyc);
      check($sformatf("sat%0d.who", k), 32'(who), 32'd1);
      check($sformatf("sat%0d.gap", k), 32'(cyc), 32'd2);
    end
    m0Req = 1;
    waitAck(4, who, cyc);
    check("sat.m0Wins", 32'(who), 32'd0);
    m0Req = 0; m1Req = 0; m1Lock = 0;
    tick();
    check("satIdle.ce", 32'(ramCe), 32'd0);
    tick();
    check("satIdle.ack", 32'({ack0, ack1}), 32'd0);

    // M0 drops REQ during ACCESS: write and ACK still complete.
    m0Req = 1; m0Wr = 1; m0Addr = 8'h30; m0Wdata = 32'h12345678;
    tick();
    check("drop.ce", 32'({ramCe, ramWr}), 32'd3);
    check("drop.addr", 32'(ramAddr), 32'h30);
    m0Req = 0;
    tick();
    check("drop.ack0", 32'(ack0), 32'd1);
    check("drop.ceOff", 32'(ramCe), 32'd0);
    tick();
    check("drop.idle", 32'({ramCe, ack0, ack1}), 32'd0);
    check("drop.mem", mem[8'h30], 32'h12345678);

    // Reset asserted during ACCESS.
    m0Req = 1; m0Wr = 1; m0Addr = 8'h40; m0Wdata = 32'hAAAA5555;
    tick();
    check("rstMid.ce", 32'(ramCe), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkAllZero("rstMid");
    tick();
    check("rstMid.noAck", 32'({ack0, ack1, ramCe}), 32'd0);
    m0Req = 1; m0Wr = 0; m0Addr = 8'h20;
    m1Req = 1; m1Wr = 0; m1Addr = 8'h10;
    #3 rstN = 1'b1;
    tick();
    check("rstTie.ce", 32'({ramCe, ramRd}), 32'd3);
    check("rstTie.addr", 32'(ramAddr), 32'h20);
    tick();
    check("rstTie.ack0", 32'({ack0, ack1}), 32'd2);
    check("rstTie.rdat0", rdata0, 32'hCAFEF00D);
    m0Req = 0; m1Req = 0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
